// File: rtl/postage_filter_dbg_pkg.sv
// rtl/postage_filter_dbg_pkg.sv - shared types and constants for the postage filter debug reporter
package postage_filter_dbg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    SEND  = 2'd2,
    HOLD  = 2'd3
  } dbg_state_t;

  localparam logic [7:0]  REPORT_MAGIC = 8'hDE;
  localparam int unsigned REPORT_BEATS = 3;

  typedef logic [1:0] beat_idx_t;

  localparam beat_idx_t LAST_BEAT = beat_idx_t'(REPORT_BEATS - 1);

endpackage

// File: rtl/postage_filter_dbg_persist.sv
// rtl/postage_filter_dbg_persist.sv - consecutive-block run counter with threshold compare
module postage_filter_dbg_persist #(
  parameter int unsigned THRESHOLD = 256
) (
  input  logic clock,
  input  logic reset,
  input  logic any,
  input  logic restart,
  output logic reached
);

  localparam int unsigned RUN_W = $clog2(THRESHOLD + 1);
  localparam logic [RUN_W-1:0] LAST_RUN = RUN_W'(THRESHOLD - 1);
  localparam logic [RUN_W-1:0] MAX_RUN  = RUN_W'(THRESHOLD);

  logic [RUN_W-1:0] run_cnt;

  // Count consecutive blocked samples; any quiet cycle or a restart drops the run to zero.
  always_ff @(posedge clock) begin
    if (reset || restart || !any) begin
      run_cnt <= '0;
    end else if (run_cnt != MAX_RUN) begin
      run_cnt <= run_cnt + RUN_W'(1);
    end
  end

  // The current blocked sample is the THRESHOLD-th in a row.
  assign reached = any && (run_cnt == LAST_RUN);

endmodule

// File: rtl/postage_filter_deadlock_reporter.sv
// rtl/postage_filter_deadlock_reporter.sv - persistent-block deadlock detector with 3-beat AXIS report
module postage_filter_deadlock_reporter
  import postage_filter_dbg_pkg::*;
#(
  parameter int unsigned NUM_MON   = 4,
  parameter int unsigned THRESHOLD = 256,
  parameter int unsigned CNT_W     = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_MON-1:0] block_in,
  input  logic               clear,
  output logic [31:0]        m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               m_axis_tlast,
  output logic               deadlock,
  output logic [NUM_MON-1:0] first_mask,
  output logic [CNT_W-1:0]   block_cycles
);

  dbg_state_t         state;
  dbg_state_t         next_state;
  beat_idx_t          beat;
  logic [31:0]        ts;
  logic [31:0]        decl_ts;
  logic [NUM_MON-1:0] decl_mask;

  logic any;
  logic reached;
  logic restart;
  logic handshake;
  logic start_run;
  logic go_send;
  logic first_clr;
  logic deadlock_clr;

  assign any       = |block_in;
  assign handshake = m_axis_tvalid && m_axis_tready;

  // Once a packet is underway or a deadlock is held, the run must start afresh after re-arm.
  assign restart = clear || (state == SEND) || (state == HOLD);

  postage_filter_dbg_persist #(
    .THRESHOLD (THRESHOLD)
  ) u_persist (
    .clock   (clock),
    .reset   (reset),
    .any     (any),
    .restart (restart),
    .reached (reached)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; clear outranks detection but cannot interrupt a packet.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:  if (!clear && any) next_state = COUNT;
      COUNT: begin
        if (clear || !any) begin
          next_state = IDLE;
        end else if (reached) begin
          next_state = SEND;
        end
      end
      SEND:  if (handshake && (beat == LAST_BEAT)) next_state = HOLD;
      HOLD:  if (clear) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Per-state control strobes for the snapshot, flag and stream registers.
  always_comb begin
    start_run    = 1'b0;
    go_send      = 1'b0;
    first_clr    = 1'b0;
    deadlock_clr = 1'b0;
    unique case (state)
      IDLE: begin
        first_clr = clear;
        start_run = any && !clear;
      end
      COUNT: begin
        first_clr = clear;
        go_send   = reached && any && !clear;
      end
      HOLD: begin
        first_clr    = clear;
        deadlock_clr = clear;
      end
      default: ;
    endcase
  end

  // Free-running timestamp used to stamp the declaration.
  always_ff @(posedge clock) begin
    if (reset) begin
      ts <= '0;
    end else begin
      ts <= ts + 32'd1;
    end
  end

  // Saturating count of blocked cycles; clear wins over the increment.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      block_cycles <= '0;
    end else if (any && (block_cycles != {CNT_W{1'b1}})) begin
      block_cycles <= block_cycles + CNT_W'(1);
    end
  end

  // Mask seen on the first cycle of a run; kept when the run dies out.
  always_ff @(posedge clock) begin
    if (reset || first_clr) begin
      first_mask <= '0;
    end else if (start_run) begin
      first_mask <= block_in;
    end
  end

  // Snapshot taken on the declaring sample so later block_in changes cannot alter the packet.
  always_ff @(posedge clock) begin
    if (reset) begin
      decl_ts   <= '0;
      decl_mask <= '0;
    end else if (go_send) begin
      decl_ts   <= ts;
      decl_mask <= block_in;
    end
  end

  // Sticky deadlock flag, dropped only by clear while holding.
  always_ff @(posedge clock) begin
    if (reset) begin
      deadlock <= 1'b0;
    end else if (go_send) begin
      deadlock <= 1'b1;
    end else if (deadlock_clr) begin
      deadlock <= 1'b0;
    end
  end

  // Stream valid and beat index; a beat only advances on an accepted handshake.
  always_ff @(posedge clock) begin
    if (reset) begin
      m_axis_tvalid <= 1'b0;
      beat          <= '0;
    end else if (go_send) begin
      m_axis_tvalid <= 1'b1;
      beat          <= '0;
    end else if (handshake) begin
      if (beat == LAST_BEAT) begin
        m_axis_tvalid <= 1'b0;
        beat          <= '0;
      end else begin
        beat <= beat + beat_idx_t'(1);
      end
    end
  end

  // Beat payload selected from registers that are frozen while the packet is in flight.
  always_comb begin
    m_axis_tdata = '0;
    m_axis_tlast = 1'b0;
    if (m_axis_tvalid) begin
      unique case (beat)
        beat_idx_t'(0): m_axis_tdata = {REPORT_MAGIC, 8'(NUM_MON), 16'(first_mask)};
        beat_idx_t'(1): m_axis_tdata = decl_ts;
        default:        m_axis_tdata = 32'(decl_mask);
      endcase
      m_axis_tlast = (beat == LAST_BEAT);
    end
  end

endmodule

// File: tb/tb_postage_filter_deadlock_reporter.sv
// tb/tb_postage_filter_deadlock_reporter.sv - directed self-checking bench for the deadlock reporter
module tb_postage_filter_deadlock_reporter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  block_in = 4'h0;
  logic        clear = 1'b0;
  logic        m_axis_tready = 1'b0;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        deadlock;
  logic [3:0]  first_mask;
  logic [31:0] block_cycles;

  int          checks = 0;
  int          errors = 0;
  int          hs_count = 0;
  int          hs_base;
  logic [31:0] tb_ts;
  logic [31:0] exp_ts;
  logic [31:0] exp_beat [3];

  postage_filter_deadlock_reporter #(
    .NUM_MON   (4),
    .THRESHOLD (8),
    .CNT_W     (32)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .block_in      (block_in),
    .clear         (clear),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .deadlock      (deadlock),
    .first_mask    (first_mask),
    .block_cycles  (block_cycles)
  );

  always #5 clock = ~clock;

  // Reference cycle counter: zero under reset, +1 per clock otherwise.
  always @(posedge clock) begin
    if (reset) tb_ts <= 32'd0;
    else       tb_ts <= tb_ts + 32'd1;
  end

  // Count accepted stream beats.
  always @(posedge clock) begin
    if (!reset && m_axis_tvalid && m_axis_tready) hs_count <= hs_count + 1;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_tvalid"}, 32'(m_axis_tvalid), 32'd0);
    chk({tag, "_tdata"}, m_axis_tdata, 32'd0);
    chk({tag, "_tlast"}, 32'(m_axis_tlast), 32'd0);
    chk({tag, "_deadlock"}, 32'(deadlock), 32'd0);
    chk({tag, "_first_mask"}, 32'(first_mask), 32'd0);
    chk({tag, "_block_cycles"}, block_cycles, 32'd0);
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    ticks(2);
    chk_all_zero("reset");
    reset = 1'b0;

    // T1: single blocker held to threshold, tready high
    block_in = 4'b0010;
    m_axis_tready = 1'b1;
    ticks(7);
    chk("t1_no_dl_at_7", 32'(deadlock), 32'd0);
    chk("t1_first_mask", 32'(first_mask), 32'h2);
    tick();
    exp_ts = tb_ts - 32'd1;
    chk("t1_dl_at_8", 32'(deadlock), 32'd1);
    chk("t1_tvalid", 32'(m_axis_tvalid), 32'd1);
    chk("t1_beat0", m_axis_tdata, 32'hDE040002);
    chk("t1_beat0_tlast", 32'(m_axis_tlast), 32'd0);
    block_in = 4'hF;
    tick();
    chk("t1_beat1", m_axis_tdata, exp_ts);
    chk("t1_beat1_tlast", 32'(m_axis_tlast), 32'd0);
    tick();
    chk("t1_beat2", m_axis_tdata, 32'h00000002);
    chk("t1_beat2_tlast", 32'(m_axis_tlast), 32'd1);
    block_in = 4'h0;
    tick();
    chk("t1_tvalid_done", 32'(m_axis_tvalid), 32'd0);
    chk("t1_dl_hold", 32'(deadlock), 32'd1);
    chk("t1_block_cycles", block_cycles, 32'd10);
    block_in = 4'hF;
    ticks(3);
    chk("t1_hold_no_pkt", 32'(m_axis_tvalid), 32'd0);
    chk("t1_hold_block_cycles", block_cycles, 32'd13);
    block_in = 4'h0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t1_clear_dl", 32'(deadlock), 32'd0);
    chk("t1_clear_first_mask", 32'(first_mask), 32'd0);
    chk("t1_clear_block_cycles", block_cycles, 32'd0);

    // T2: 7 high, 1 low, 7 high -> no deadlock
    block_in = 4'b0001;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("t2_tvalid_run_a", 32'(m_axis_tvalid), 32'd0);
    end
    block_in = 4'b0000;
    tick();
    block_in = 4'b0001;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("t2_tvalid_run_b", 32'(m_axis_tvalid), 32'd0);
    end
    block_in = 4'b0000;
    tick();
    chk("t2_no_dl", 32'(deadlock), 32'd0);
    chk("t2_block_cycles", block_cycles, 32'd14);
    chk("t2_first_mask_kept", 32'(first_mask), 32'h1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t2_clear_block_cycles", block_cycles, 32'd0);

    // T3: backpressure of 5 cycles on every beat
    m_axis_tready = 1'b0;
    block_in = 4'b0100;
    ticks(8);
    exp_ts = tb_ts - 32'd1;
    chk("t3_dl", 32'(deadlock), 32'd1);
    block_in = 4'b0000;
    hs_base = hs_count;
    exp_beat[0] = 32'hDE040004;
    exp_beat[1] = exp_ts;
    exp_beat[2] = 32'h00000004;
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < 5; k++) begin
        tick();
        chk("t3_tvalid_held", 32'(m_axis_tvalid), 32'd1);
        chk("t3_tdata_held", m_axis_tdata, exp_beat[b]);
        chk("t3_tlast_held", 32'(m_axis_tlast), 32'(b == 2));
      end
      m_axis_tready = 1'b1;
      tick();
      m_axis_tready = 1'b0;
    end
    chk("t3_tvalid_after", 32'(m_axis_tvalid), 32'd0);
    m_axis_tready = 1'b1;
    ticks(3);
    chk("t3_handshakes", 32'(hs_count - hs_base), 32'd3);
    chk("t3_tvalid_quiet", 32'(m_axis_tvalid), 32'd0);
    clear = 1'b1;
    tick();
    clear = 1'b0;

    // T4: clear during beat1 is ignored by the FSM but zeroes block_cycles
    block_in = 4'b0001;
    ticks(8);
    exp_ts = tb_ts - 32'd1;
    chk("t4_beat0", m_axis_tdata, 32'hDE040001);
    tick();
    chk("t4_beat1", m_axis_tdata, exp_ts);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t4_block_cycles_zero", block_cycles, 32'd0);
    chk("t4_dl_kept", 32'(deadlock), 32'd1);
    chk("t4_tvalid_kept", 32'(m_axis_tvalid), 32'd1);
    chk("t4_beat2", m_axis_tdata, 32'h00000001);
    chk("t4_beat2_tlast", 32'(m_axis_tlast), 32'd1);
    chk("t4_first_mask_kept", 32'(first_mask), 32'h1);
    block_in = 4'b0000;
    tick();
    chk("t4_tvalid_done", 32'(m_axis_tvalid), 32'd0);
    chk("t4_dl_hold", 32'(deadlock), 32'd1);
    chk("t4_block_cycles_still0", block_cycles, 32'd0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t4_hold_clear_dl", 32'(deadlock), 32'd0);
    chk("t4_hold_clear_first_mask", 32'(first_mask), 32'd0);

    // T5: first mask differs from declaring mask
    block_in = 4'b0001;
    tick();
    block_in = 4'b1001;
    ticks(6);
    chk("t5_no_dl_at_7", 32'(deadlock), 32'd0);
    tick();
    exp_ts = tb_ts - 32'd1;
    chk("t5_dl", 32'(deadlock), 32'd1);
    chk("t5_first_mask", 32'(first_mask), 32'h1);
    chk("t5_beat0", m_axis_tdata, 32'hDE040001);
    tick();
    chk("t5_beat1", m_axis_tdata, exp_ts);
    tick();
    chk("t5_beat2", m_axis_tdata, 32'h00000009);
    chk("t5_beat2_tlast", 32'(m_axis_tlast), 32'd1);
    block_in = 4'b0000;
    tick();
    chk("t5_tvalid_done", 32'(m_axis_tvalid), 32'd0);
    clear = 1'b1;
    tick();
    clear = 1'b0;

    // T6: reset in the middle of a packet, then a fresh full packet
    block_in = 4'b0010;
    ticks(8);
    chk("t6_tvalid_pre", 32'(m_axis_tvalid), 32'd1);
    tick();
    reset = 1'b1;
    block_in = 4'b0000;
    tick();
    chk_all_zero("t6_reset");
    reset = 1'b0;
    block_in = 4'b1000;
    ticks(7);
    chk("t6_no_dl_at_7", 32'(deadlock), 32'd0);
    tick();
    exp_ts = tb_ts - 32'd1;
    chk("t6_dl", 32'(deadlock), 32'd1);
    chk("t6_beat0", m_axis_tdata, 32'hDE040008);
    tick();
    chk("t6_beat1", m_axis_tdata, exp_ts);
    tick();
    chk("t6_beat2", m_axis_tdata, 32'h00000008);
    chk("t6_beat2_tlast", 32'(m_axis_tlast), 32'd1);
    block_in = 4'b0000;
    tick();
    chk("t6_tvalid_done", 32'(m_axis_tvalid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
